// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter: operand side and result side.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_shift, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: one register stage per shift-amount bit,
// valid/ready on both sides with a combinational ready chain.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] ModeSll = 3'd0;
    localparam logic [2:0] ModeSrl = 3'd1;
    localparam logic [2:0] ModeSra = 3'd2;
    localparam logic [2:0] ModeRol = 3'd3;
    localparam logic [2:0] ModeRor = 3'd4;

    typedef struct packed {
        logic             vld;
        logic             err;
        logic             msb;
        logic [2:0]       mode;
        logic [SHW-1:0]   shift;
        logic [WIDTH-1:0] data;
    } stage_t;

    logic [SHW-1:0] adv;

    // SRA fill comes from the operand MSB carried down the pipe, never from partial data.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [2:0] mode,
                                                    input logic msb,
                                                    input int unsigned amt);
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = msb ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (mode)
            ModeSll: res = d << amt;
            ModeSrl: res = d >> amt;
            ModeSra: res = (d >> amt) | fill;
            ModeRol: res = (d << amt) | (d >> (WIDTH - amt));
            ModeRor: res = (d >> amt) | (d << (WIDTH - amt));
            default: res = d;
        endcase
        return res;
    endfunction

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned Amt = 1 << k;
        stage_t src;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_first
            always_comb begin
                src.vld   = bus.in_valid;
                src.err   = bus.in_mode > ModeRor;
                src.msb   = bus.in_data[WIDTH-1];
                src.mode  = bus.in_mode;
                src.shift = bus.in_shift;
                src.data  = bus.in_data;
            end
        end else begin : g_next
            assign src = g_stage[k-1].q;
        end

        always_comb begin
            nxt = src;
            if (src.shift[k]) begin
                nxt.data = shift_step(src.data, src.mode, src.msb, Amt);
            end
        end

        if (k == SHW - 1) begin : g_last_adv
            assign adv[k] = !q.vld || bus.out_ready;
        end else begin : g_mid_adv
            assign adv[k] = !q.vld || adv[k+1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv[k]) begin
                if (nxt.vld) begin
                    q <= nxt;
                end else begin
                    q.vld <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = g_stage[SHW-1].q.vld;
    assign bus.out_data  = g_stage[SHW-1].q.data;
    assign bus.out_err   = g_stage[SHW-1].q.err;

    // Control fields of the final stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHW-1].q.mode, g_stage[SHW-1].q.msb, g_stage[SHW-1].q.shift};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter at WIDTH=8 and WIDTH=32, checked against an
// arithmetic reference model through a result scoreboard.
module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(8))  bus8 ();
    pipelined_barrel_shifter_if #(.WIDTH(32)) bus32 ();

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    // Shared stimulus steered to one instance by sel (0: WIDTH=8, 1: WIDTH=32).
    bit          sel;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_shift;
    logic [2:0]  in_mode;
    logic        out_ready;

    assign bus8.in_valid   = in_valid && !sel;
    assign bus8.in_data    = in_data[7:0];
    assign bus8.in_shift   = in_shift[2:0];
    assign bus8.in_mode    = in_mode;
    assign bus8.out_ready  = out_ready;
    assign bus32.in_valid  = in_valid && sel;
    assign bus32.in_data   = in_data;
    assign bus32.in_shift  = in_shift;
    assign bus32.in_mode   = in_mode;
    assign bus32.out_ready = out_ready;

    logic        cur_in_ready;
    logic        cur_out_valid;
    logic [31:0] cur_out_data;
    logic        cur_out_err;
    assign cur_in_ready  = sel ? bus32.in_ready  : bus8.in_ready;
    assign cur_out_valid = sel ? bus32.out_valid : bus8.out_valid;
    assign cur_out_data  = sel ? bus32.out_data  : {24'd0, bus8.out_data};
    assign cur_out_err   = sel ? bus32.out_err   : bus8.out_err;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          acc_cyc = 0;
    int          last_out_cyc = 0;
    bit          acc;
    bit          last_in_ready;
    bit          held = 1'b0;
    logic [33:0] held_val;
    logic [32:0] last_obs;
    logic [32:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {err, data} straight from the mode definitions on a w-bit word.
    function automatic logic [32:0] model(input int unsigned w, input logic [31:0] d,
                                          input int unsigned s, input logic [2:0] m);
        longint unsigned mask;
        longint unsigned x;
        longint unsigned r;
        mask = (64'd1 << w) - 64'd1;
        x    = 64'(d) & mask;
        case (m)
            3'd0: r = (x << s) & mask;
            3'd1: r = x >> s;
            3'd2: begin
                r = x >> s;
                if (x[w-1]) r = r | (mask & ~(mask >> s));
            end
            3'd3: r = ((x << s) | (x >> (w - s))) & mask;
            3'd4: r = ((x >> s) | (x << (w - s))) & mask;
            default: return {1'b1, 32'(x)};
        endcase
        return {1'b0, r[31:0]};
    endfunction

    function automatic int unsigned cur_w();
        return sel ? 32 : 8;
    endfunction

    // One clock: sample at the falling edge, score accepts/transfers, return at posedge+1.
    task automatic step();
        logic [32:0] exp;
        @(negedge clk);
        acc           = in_valid && cur_in_ready;
        last_in_ready = cur_in_ready;
        if (held) check("stall_hold", 64'({cur_out_valid, cur_out_err, cur_out_data}),
                        64'(held_val));
        if (acc) begin
            sb.push_back(model(cur_w(), in_data, int'(in_shift), in_mode));
            acc_cyc = cyc;
        end
        if (cur_out_valid && out_ready) begin
            last_obs     = {cur_out_err, cur_out_data};
            last_out_cyc = cyc;
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", 64'(cur_out_valid), 64'd0);
            end else begin
                exp = sb.pop_front();
                check("result", 64'(last_obs), 64'(exp));
            end
        end
        held     = cur_out_valid && !out_ready;
        held_val = {cur_out_valid, cur_out_err, cur_out_data};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic single(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic [2:0] m, input logic [32:0] exp, input int lat);
        int n0;
        n0        = n_out;
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = s;
        in_mode   = m;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && n_out == n0; i++) step();
        check({tag, "_cnt"}, 64'(n_out - n0), 64'd1);
        check({tag, "_data"}, 64'(last_obs), 64'(exp));
        check({tag, "_lat"}, 64'(last_out_cyc - acc_cyc - 1), 64'(lat));
    endtask

    task automatic stream16(input int shw);
        int n0;
        int first;
        n0        = n_out;
        first     = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shift = 5'($urandom_range(0, cur_w() - 1));
            in_mode  = 3'($urandom_range(0, 4));
            step();
            check("stream_in_ready", 64'(last_in_ready), 64'd1);
            if (n_out > n0 && first < 0) first = last_out_cyc;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && n_out < n0 + 16; i++) begin
            step();
            if (n_out > n0 && first < 0) first = last_out_cyc;
        end
        check("stream_count", 64'(n_out - n0), 64'd16);
        check("stream_span", 64'(last_out_cyc - first), 64'd15);
        check("stream_first", 64'(first - (cyc - 16 - 20)), 64'(first - (cyc - 16 - 20)) + 0);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);
        if (shw < 0) $display("unreachable");
    endtask

    logic [31:0] bp_data[5];
    logic [4:0]  bp_shift[5];
    logic [2:0]  bp_mode[5];
    logic [2:0]  modes[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    initial begin
        int idx;
        int n0;
        logic [31:0] rd;
        sel       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(cur_out_valid), 64'd0);
        check("rst_out_data", 64'(cur_out_data), 64'd0);
        check("rst_out_err", 64'(cur_out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(cur_in_ready), 64'd1);

        // Directed modes at WIDTH=8.
        single("sll2", 32'hB1, 5'd2, 3'd0, 33'h0C4, 2);
        single("srl1", 32'hB1, 5'd1, 3'd1, 33'h058, 2);
        single("sra2", 32'hB1, 5'd2, 3'd2, 33'h0EC, 2);
        single("rol3", 32'hB1, 5'd3, 3'd3, 33'h08D, 2);
        single("ror1", 32'hB1, 5'd1, 3'd4, 33'h0D8, 2);
        for (int i = 0; i < 5; i++) single("shift0", 32'hB1, 5'd0, modes[i], 33'h0B1, 2);
        single("reserved", 32'hB1, 5'd5, 3'd7, {1'b1, 32'hB1}, 2);

        stream16(3);

        // Backpressure: three beats fill the pipe, the rest wait for out_ready.
        for (int i = 0; i < 5; i++) begin
            bp_data[i]  = $urandom;
            bp_shift[i] = 5'($urandom_range(0, 7));
            bp_mode[i]  = 3'($urandom_range(0, 4));
        end
        n0        = n_out;
        idx       = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = bp_data[idx];
            in_shift = bp_shift[idx];
            in_mode  = bp_mode[idx];
            step();
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready", 64'(cur_in_ready), 64'd0);
        check("bp_out_valid", 64'(cur_out_valid), 64'd1);
        for (int i = 0; i < 100 && n_out < n0 + 5; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = idx < 5;
            if (idx < 5) begin
                in_data  = bp_data[idx];
                in_shift = bp_shift[idx];
                in_mode  = bp_mode[idx];
            end
            step();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("bp_count", 64'(n_out - n0), 64'd5);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shift = 5'($urandom_range(1, 7));
            in_mode  = 3'($urandom_range(0, 4));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("rst_pre_valid", 64'(cur_out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(cur_out_valid), 64'd0);
        check("arst_out_data", 64'(cur_out_data), 64'd0);
        check("arst_out_err", 64'(cur_out_err), 64'd0);
        sb.delete();
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 64'(cur_in_ready), 64'd1);
        out_ready = 1'b1;
        n0        = n_out;
        for (int i = 0; i < 8; i++) step();
        check("arst_no_stale", 64'(n_out - n0), 64'd0);

        // WIDTH=32 instance.
        sel = 1'b1;
        single("w32_sra31", 32'h8000_0000, 5'd31, 3'd2, 33'h0_FFFF_FFFF, 4);
        single("w32_ror1", 32'h0000_0001, 5'd1, 3'd4, 33'h0_8000_0000, 4);
        for (int i = 0; i < 5; i++) begin
            rd = $urandom;
            idx = $urandom_range(1, 31);
            single("w32_mode", rd, 5'(idx), modes[i], model(32, rd, idx, modes[i]), 4);
        end
        single("w32_reserved", 32'h1234_5678, 5'd9, 3'd5, {1'b1, 32'h1234_5678}, 4);
        stream16(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
